// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter/controller.
// FSM states and requester identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INT_RSP,
    EXT_WAIT,
    RSP
  } state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_t;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/mem_arb_sram.sv
// Byte-enabled single-port word SRAM.
// Synchronous read with one cycle of latency.
module mem_arb_sram #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned INT_WORDS = 2048
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic                         we,
  input  logic [DATA_W/8-1:0]          be,
  input  logic [$clog2(INT_WORDS)-1:0] idx,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [INT_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) begin
            mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Two-port (fetch/data) round-robin memory controller with an
// internal word SRAM region and a req/ack external bus with timeout.
module mem_arb_ctrl
  import mem_arb_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] INT_BASE    = 'h8000_0000,
  parameter int unsigned       INT_WORDS   = 2048,
  parameter int unsigned       EXT_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rsp_data,
  output logic                i_rsp_err,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W/8-1:0] d_req_be,
  input  logic [DATA_W-1:0]   d_req_wdata,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                d_rsp_err,
  output logic                ext_req,
  output logic [ADDR_W-1:0]   ext_addr,
  output logic                ext_we,
  output logic [DATA_W/8-1:0] ext_be,
  output logic [DATA_W-1:0]   ext_wdata,
  input  logic                ext_ack,
  input  logic [DATA_W-1:0]   ext_rdata,
  output logic                busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(INT_WORDS);
  localparam int unsigned CNT_W = $clog2(EXT_TIMEOUT + 1);

  localparam logic [ADDR_W:0] REGION =
    (ADDR_W+1)'(INT_WORDS * 4);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(EXT_TIMEOUT - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t state;
  state_t state_nx;
  port_t  last_port;
  port_t  port_q;
  port_t  sel_port;
  req_t   req_d;
  req_t   req_q;

  logic              idle;
  logic              gnt_i;
  logic              gnt_d;
  logic              accept;
  logic              mis;
  logic              internal;
  logic              sram_en;
  logic              to_hit;
  logic [ADDR_W:0]   off;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] sram_rdata;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic [CNT_W-1:0]  cnt;
  logic              rsp_v;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  // Data wins a tie unless it was the last port served.
  assign idle     = (state == IDLE);
  assign gnt_d    = d_req_valid &&
                    (!i_req_valid || last_port == PORT_I);
  assign gnt_i    = i_req_valid && !gnt_d;
  assign accept   = idle && (gnt_i || gnt_d);
  assign sel_port = gnt_d ? PORT_D : PORT_I;

  always_comb begin
    req_d = '0;
    if (gnt_d) begin
      req_d.addr  = d_req_addr;
      req_d.we    = d_req_we;
      req_d.be    = d_req_be;
      req_d.wdata = d_req_wdata;
    end else begin
      req_d.addr  = i_req_addr;
      req_d.be    = '1;
    end
  end

  // Extra bit keeps addresses below the base from wrapping inside.
  assign off      = {1'b0, req_d.addr} - {1'b0, INT_BASE};
  assign mis      = is_misaligned(req_d.addr[1:0]);
  assign internal = !off[ADDR_W] && (off < REGION);
  assign idx      = off[IDX_W+1:2];
  assign sram_en  = accept && !mis && internal;
  assign to_hit   = (cnt == CNT_LAST);

  mem_arb_sram #(
    .DATA_W    (DATA_W),
    .INT_WORDS (INT_WORDS)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (req_d.we),
    .be    (req_d.be),
    .idx   (idx),
    .wdata (req_d.wdata),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            mis:              state_nx = RSP;
            (!mis && internal): state_nx = INT_RSP;
            default:          state_nx = EXT_WAIT;
          endcase
        end
      end
      INT_RSP:  state_nx = IDLE;
      EXT_WAIT: begin
        if (ext_ack || to_hit) begin
          state_nx = RSP;
        end
      end
      RSP:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_port  <= PORT_I;
      port_q     <= PORT_I;
      req_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cnt        <= '0;
    end else begin
      if (accept) begin
        req_q      <= req_d;
        port_q     <= sel_port;
        last_port  <= sel_port;
        rsp_data_q <= '0;
        rsp_err_q  <= mis;
      end
      if (state == EXT_WAIT) begin
        if (ext_ack) begin
          rsp_data_q <= req_q.we ? '0 : ext_rdata;
          rsp_err_q  <= 1'b0;
          cnt        <= '0;
        end else if (to_hit) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
          cnt        <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rsp_v    = (state == INT_RSP) || (state == RSP);
    rsp_data = '0;
    rsp_err  = 1'b0;
    if (state == INT_RSP && !req_q.we) begin
      rsp_data = sram_rdata;
    end
    if (state == RSP) begin
      rsp_data = rsp_data_q;
      rsp_err  = rsp_err_q;
    end

    i_req_ready = idle && gnt_i;
    d_req_ready = idle && gnt_d;

    i_rsp_valid = rsp_v && (port_q == PORT_I);
    i_rsp_data  = i_rsp_valid ? rsp_data : '0;
    i_rsp_err   = i_rsp_valid && rsp_err;
    d_rsp_valid = rsp_v && (port_q == PORT_D);
    d_rsp_data  = d_rsp_valid ? rsp_data : '0;
    d_rsp_err   = d_rsp_valid && rsp_err;

    ext_req   = (state == EXT_WAIT);
    ext_addr  = ext_req ? req_q.addr  : '0;
    ext_we    = ext_req && req_q.we;
    ext_be    = ext_req ? req_q.be    : '0;
    ext_wdata = ext_req ? req_q.wdata : '0;

    busy = !idle;
  end

endmodule
